// File: rtl/squeeze_output_unloader.sv
// Purpose : drains one captured rate block as W-bit words (lane 0 first) onto a
//           valid/ready stream and hands the buffer back to the permute FSM.
// Latency : write in cycle t -> first word valid in t+1; one word per cycle;
//           one idle cycle between consecutive blocks.
// Backpressure: dout_ready low holds dout/dout_last stable; writes that arrive
//           while a block is still draining are dropped and flagged.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rate_data, block_words        block to capture and its word count (0 => MAX_WORDS)
//   output_buffer_we              capture strobe
//   last_output_block_wr          block is the message's final output block
//   output_buffer_available_clr   clears output_buffer_available
//   output_buffer_available       buffer empty, next block may be written
//   dout, dout_valid, dout_ready  output word stream
//   dout_last                     final word of the message
//   overrun_err                   sticky: write seen while still draining
module squeeze_output_unloader #(
  parameter  int W          = 64,
  parameter  int MAX_WORDS  = 21,
  localparam int RATE_WIDTH = W * MAX_WORDS,
  localparam int CW         = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RATE_WIDTH-1:0] rate_data,
  input  logic [CW-1:0]         block_words,
  input  logic                  output_buffer_we,
  input  logic                  last_output_block_wr,
  input  logic                  output_buffer_available_clr,
  output logic                  output_buffer_available,
  output logic [W-1:0]          dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  overrun_err
);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                state_q, state_d;
  logic [RATE_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  avail_q, avail_d;
  logic                  ovr_q, ovr_d;
  logic [CW-1:0]         words_clamped;

  // A zero or out-of-range count means "full block at the largest rate".
  assign words_clamped = (block_words == '0 || block_words > CW'(MAX_WORDS))
                         ? CW'(MAX_WORDS) : block_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      avail_q <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      avail_q <= avail_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    avail_d = avail_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      EMPTY: begin
        if (output_buffer_we) begin
          shreg_d = rate_data;
          cnt_d   = words_clamped;
          last_d  = last_output_block_wr;
          state_d = SEND;
        end
      end
      SEND: begin
        // Block still draining: the write is dropped, only the flag records it.
        if (output_buffer_we) ovr_d = 1'b1;
        if (dout_ready) begin
          shreg_d = shreg_q >> W;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = EMPTY;
            avail_d = 1'b1;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // Clear has priority over the final-word set in the same cycle.
    if (output_buffer_available_clr) avail_d = 1'b0;
  end

  assign output_buffer_available = avail_q;
  assign dout_valid              = (state_q == SEND);
  assign dout                    = shreg_q[W-1:0];
  assign dout_last               = dout_valid && last_q && (cnt_q == CW'(1));
  assign overrun_err             = ovr_q;

endmodule

// File: tb/tb_squeeze_output_unloader.sv
module tb_squeeze_output_unloader;

  localparam int W  = 64;
  localparam int MW = 21;
  localparam int RW = W * MW;
  localparam int CW = $clog2(MW + 1);

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [RW-1:0] rate_data;
  logic [CW-1:0] block_words;
  logic          we;
  logic          last_wr;
  logic          clr;
  logic          avail;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          overrun_err;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  squeeze_output_unloader #(.W(W), .MAX_WORDS(MW)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .rate_data                   (rate_data),
    .block_words                 (block_words),
    .output_buffer_we            (we),
    .last_output_block_wr        (last_wr),
    .output_buffer_available_clr (clr),
    .output_buffer_available     (avail),
    .dout                        (dout),
    .dout_valid                  (dout_valid),
    .dout_ready                  (dout_ready),
    .dout_last                   (dout_last),
    .overrun_err                 (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] make_block(input int base);
    logic [RW-1:0] b;
    b = '0;
    for (int i = 0; i < MW; i++) b[i*W +: W] = 64'(base + i);
    return b;
  endfunction

  // Drives one write (with the matching available clear) and records the words
  // the stream is expected to carry. First word is sampled at the next negedge.
  task automatic do_write(input logic [RW-1:0] data, input logic [CW-1:0] nw,
                          input logic lst, input int nexp);
    exp_t e;
    @(negedge clk);
    rate_data   = data;
    block_words = nw;
    last_wr     = lst;
    we          = 1'b1;
    clr         = 1'b1;
    for (int i = 0; i < nexp; i++) begin
      e.d = data[i*W +: W];
      e.l = lst && (i == nexp - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    we  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; clr = 1'b0; last_wr = 1'b0; dout_ready = 1'b0;
    rate_data = '0; block_words = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (avail !== 1'b1 || dout_valid !== 1'b0 || overrun_err !== 1'b0 ||
        dout_last !== 1'b0 || dout !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: avail=%b valid=%b ovr=%b last=%b dout=%0h, want 1 0 0 0 0",
               avail, dout_valid, overrun_err, dout_last, dout);
    end
  endtask

  task automatic test_full_block();
    exp_t e;
    sb.delete();
    dout_ready = 1'b1;
    do_write(make_block(1), CW'(21), 1'b1, 21);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL full_valid cycle %0d: valid=%b, want 1", c, dout_valid);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (dout !== e.d || dout_last !== e.l) begin
          n_fail++;
          $display("FAIL full_word %0d: dout=%0h last=%b, want %0h %b", c, dout, dout_last, e.d, e.l);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (avail !== 1'b0) begin
          n_fail++;
          $display("FAIL full_avail_clr: avail=%b, want 0", avail);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (avail !== 1'b1 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: avail=%b valid=%b last=%b, want 1 0 0", avail, dout_valid, dout_last);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int got;
    logic held_v;
    logic [W-1:0] held_d;
    sb.delete();
    got = 0; held_v = 1'b0; held_d = '0;
    dout_ready = 1'b0;
    do_write(make_block(32'h7000), CW'(17), 1'b0, 17);
    for (int c = 0; c < 200 && got < 17; c++) begin
      @(negedge clk);
      if (held_v) begin
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== held_d) begin
          n_fail++;
          $display("FAIL stall_hold cycle %0d: valid=%b dout=%0h, want 1 %0h", c, dout_valid, dout, held_d);
        end
      end
      dout_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (dout_valid) begin
        n_checks++;
        if (dout_last !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_last cycle %0d: last=%b, want 0", c, dout_last);
        end
        if (dout_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL stall_extra: dout=%0h with nothing expected", dout);
          end else begin
            e = sb.pop_front();
            if (dout !== e.d) begin
              n_fail++;
              $display("FAIL stall_word %0d: dout=%0h, want %0h", got, dout, e.d);
            end
          end
          got++;
        end
      end
      held_v = dout_valid && !dout_ready;
      held_d = dout;
    end
    dout_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (got != 17 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: words=%0d valid_after=%b, want 17 0", got, dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [RW-1:0] blk_b;
    int got, bubbles;
    bit b_done;
    sb.delete();
    got = 0; bubbles = 0; b_done = 1'b0;
    blk_b = make_block(32'h20);
    dout_ready = 1'b1;
    do_write(make_block(32'h10), CW'(4), 1'b0, 4);
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      we = 1'b0; clr = 1'b0;
      if (!b_done && avail) begin
        rate_data = blk_b; block_words = CW'(4); last_wr = 1'b1; we = 1'b1; clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
          e.d = blk_b[i*W +: W];
          e.l = (i == 3);
          sb.push_back(e);
        end
        b_done = 1'b1;
      end
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: dout=%0h with nothing expected", dout);
        end else begin
          e = sb.pop_front();
          if (dout !== e.d || dout_last !== e.l) begin
            n_fail++;
            $display("FAIL b2b_word %0d: dout=%0h last=%b, want %0h %b", got, dout, dout_last, e.d, e.l);
          end
        end
        got++;
      end else if (got > 0) begin
        bubbles++;
      end
    end
    we = 1'b0; clr = 1'b0;
    n_checks++;
    if (got != 8 || bubbles != 1) begin
      n_fail++;
      $display("FAIL b2b_count: words=%0d bubbles=%0d, want 8 1", got, bubbles);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int got;
    sb.delete();
    got = 0;
    dout_ready = 1'b1;
    do_write(make_block(32'h300), CW'(5), 1'b1, 5);
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      we = 1'b0;
      if (c == 0) begin
        n_checks++;
        if (overrun_err !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_pre: overrun_err=%b, want 0", overrun_err);
        end
      end
      if (c == 1) begin
        rate_data = make_block(32'hDEAD00); block_words = CW'(3); last_wr = 1'b0; we = 1'b1;
      end
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ovr_extra: dout=%0h with nothing expected", dout);
        end else begin
          e = sb.pop_front();
          if (dout !== e.d || dout_last !== e.l) begin
            n_fail++;
            $display("FAIL ovr_word %0d: dout=%0h last=%b, want %0h %b", got, dout, dout_last, e.d, e.l);
          end
        end
        got++;
      end
    end
    we = 1'b0;
    for (int c = 0; c < 10 && !avail; c++) @(negedge clk);
    n_checks++;
    if (got != 5 || overrun_err !== 1'b1 || avail !== 1'b1 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first_block: words=%0d ovr=%b avail=%b valid=%b, want 5 1 1 0",
               got, overrun_err, avail, dout_valid);
    end
    // Zero word count: full MAX_WORDS block.
    do_write(make_block(32'h100), CW'(0), 1'b0, MW);
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!dout_valid) break;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL zero_extra: dout=%0h with nothing expected", dout);
      end else begin
        e = sb.pop_front();
        if (dout !== e.d || dout_last !== e.l) begin
          n_fail++;
          $display("FAIL zero_word %0d: dout=%0h last=%b, want %0h %b", got, dout, dout_last, e.d, e.l);
        end
      end
      got++;
    end
    n_checks++;
    if (got != MW || overrun_err !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_count: words=%0d ovr=%b, want %0d 1", got, overrun_err, MW);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    dout_ready = 1'b1;
    do_write(make_block(32'h400), CW'(21), 1'b1, 21);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if (dout_valid !== 1'b1 || dout !== e.d) begin
        n_fail++;
        $display("FAIL rstmid_word %0d: valid=%b dout=%0h, want 1 %0h", c, dout_valid, dout, e.d);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0 || avail !== 1'b1 || overrun_err !== 1'b0 ||
        dout_last !== 1'b0 || dout !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b avail=%b ovr=%b last=%b dout=%0h, want 0 1 0 0 0",
               dout_valid, avail, overrun_err, dout_last, dout);
    end
    #1;
    rst = 1'b0;
    sb.delete();
    do_write(make_block(32'h500), CW'(2), 1'b1, 2);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_checks++;
      e = sb.pop_front();
      if (dout_valid !== 1'b1 || dout !== e.d || dout_last !== e.l) begin
        n_fail++;
        $display("FAIL rstmid_new %0d: valid=%b dout=%0h last=%b, want 1 %0h %b",
                 c, dout_valid, dout, dout_last, e.d, e.l);
      end
    end
    @(negedge clk);
    n_checks++;
    if (dout_valid !== 1'b0 || avail !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_done: valid=%b avail=%b, want 0 1", dout_valid, avail);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_block();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
